stream_arb_mux: RTL
===================

Name: stream_arb_mux

Overview:
- Parametrised N-to-1 streaming multiplexer with built-in arbitration and a registered output stage.
- Successor to the fixed-size combinational muxes: channel count and width are parameters, inputs carry valid/ready handshakes, and the select is produced internally by an arbiter.
- Used wherever several producers share one consumer, e.g. register-file/LSU write-back sources or instruction/data memory requestors feeding one bus.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..32.
- DATA_BITS, 32, payload width per channel.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_BITS, derived localparam, max(1, $clog2(NUM_CH)); width of the channel index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel request; bit i belongs to channel i.
- in_data  in  NUM_CH*DATA_BITS  flattened payloads; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
- in_ready  out  NUM_CH  per-channel accept, combinational; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_BITS  registered payload.
- out_sel  out  SEL_BITS  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (reset=1 at a clock edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer set to 0, so channel 0 has highest priority.
  - in_ready=0 for the whole cycle in which reset is high.
  - Reset mid-transfer discards any held beat; no input is accepted in that cycle.
- Load enable: load = ~out_valid | out_ready, i.e. the output register is empty or is being drained this cycle.
- Grant:
  - Combinational, one-hot over in_valid.
  - ARB_MODE=0: search starts at pointer p and proceeds p, p+1, …, NUM_CH-1, 0, …, p-1; the first valid channel wins.
  - ARB_MODE=1: the lowest-index valid channel wins; the pointer is ignored.
- Handshakes:
  - in_ready[i] = load & grant[i] & ~reset.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
- On an input transfer from channel k:
  - out_data <= in_data[k], out_sel <= k, out_valid <= 1.
  - ARB_MODE=0: pointer <= (k+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- Output drained with no input transfer: out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid & ~out_ready):
  - out_data, out_sel and out_valid hold stable.
  - All in_ready are 0.
  - The pointer holds.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one; sustained throughput is 1 beat/cycle.
- Latency: an input accepted at edge n appears on out_valid/out_data from edge n onward, i.e. one register stage.
- Input rules:
  - The pointer advances only on a grant; a cycle with no valid inputs leaves it unchanged.
  - Channels not granted are not consumed; the producer must hold in_valid and in_data until accepted.
  - in_ready does not depend on out_valid of the same channel in any other way, so there is no combinational loop back to in_valid.
- Fairness: ARB_MODE=0 guarantees that a continuously valid channel is granted within NUM_CH accepted beats.
- No X propagation: with in_valid all 0, grant is 0 and in_ready is 0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → out_valid=0, out_data=0, out_sel=0, in_ready=0000; after release with in_valid=0000 → outputs unchanged.
- Single channel: NUM_CH=4, out_ready=1, in_valid=0100, in_data[2]=0xDEADBEEF → in_ready=0100 that cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2.
- Round-robin fairness: ARB_MODE=0, all four valid, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 with one beat per cycle.
- Backpressure: out_valid=1 holding 0x11 (sel 1), out_ready=0 for 3 cycles with in_valid=1111 → in_ready=0000, out_data stays 0x11, pointer stays 2. Raise out_ready → next beat comes from channel 2.
- Fixed priority: ARB_MODE=1, in_valid=1010, out_ready=1 → channel 1 wins repeatedly and channel 3 is starved; drop in_valid[1] → out_sel=3 next beat.
- Reset mid-operation: out_valid=1, pointer=3, assert reset for one cycle with in_valid=1111 → no input accepted, out_valid=0, and the next grant goes to channel 0.

Source files
------------

// File: rtl/stream_arb_mux.sv
// N-to-1 streaming multiplexer: an internal arbiter (round-robin or fixed priority)
// picks one valid producer per cycle and loads a single registered output stage.
module stream_arb_mux #(
  parameter int NUM_CH    = 4,
  parameter int DATA_BITS = 32,
  parameter int ARB_MODE  = 0,
  localparam int SEL_BITS = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*DATA_BITS-1:0] in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        out_valid,
  output logic [DATA_BITS-1:0]        out_data,
  output logic [SEL_BITS-1:0]         out_sel,
  input  logic                        out_ready
);

  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] search_start;
  logic [NUM_CH-1:0]   grant;
  logic [SEL_BITS-1:0] grant_sel;
  logic                grant_any;
  logic                load;
  logic                take;
  logic [SEL_BITS-1:0] ptr_next;

  assign load         = ~out_valid | out_ready;
  assign search_start = (ARB_MODE == 0) ? rr_ptr : '0;

  // Circular search from search_start; fixed priority just starts at channel 0.
  always_comb begin : arb
    int idx;
    grant     = '0;
    grant_sel = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = int'(search_start) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_any && in_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_sel  = SEL_BITS'(idx);
      end
    end
  end

  assign in_ready = (load && !reset) ? grant : '0;
  assign take     = load & grant_any & ~reset;
  assign ptr_next = (grant_sel == SEL_BITS'(NUM_CH - 1)) ? '0 : grant_sel + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_sel)*DATA_BITS +: DATA_BITS];
      out_sel   <= grant_sel;
      if (ARB_MODE == 0) rr_ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
